uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter.
// A small drain FSM pops one byte per transmitter ready/busy/ready cycle.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf,
  output logic                  o_tx_go,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {PW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GO,
    S_WAIT_BUSY,
    S_WAIT_READY
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            go_q, go_d;
  logic            push, pop;

  assign push = i_wr_en & ~full_q;
  assign pop  = (state_q == S_IDLE) & ~empty_q & i_tx_ready;

  always_comb begin
    state_d   = state_q;
    go_d      = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_GO;
          go_d      = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      S_GO: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i_tx_ready) state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (i_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    // a dropped write beats a clear in the same cycle
    if (i_wr_en && full_q) ovf_d = 1'b1;
    else if (i_clr_ovf)    ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      go_q      <= go_d;
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_tx_go    = go_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus hand sequences
// with a simple transmitter model that drops ready after each go.
module tb_uart_tx_fifo;

  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          ovf;
  logic          clr;
  logic          go;
  logic [7:0]    tx_data;
  logic          tx_ready;

  logic          ready_man;
  logic          ready_mdl = 1'b1;
  logic          model_en;
  int            busy = 0;
  logic [7:0]    tx_log [$];
  int            go_seen = 0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign tx_ready = model_en ? ready_mdl : ready_man;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (ovf),
    .i_clr_ovf  (clr),
    .o_tx_go    (go),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready)
  );

  // transmitter model: busy for three cycles after each go pulse
  always @(negedge clk) begin
    if (go) begin
      tx_log.push_back(tx_data);
      go_seen++;
    end
    if (!model_en) begin
      ready_mdl = 1'b1;
      busy = 0;
    end else if (go) begin
      ready_mdl = 1'b0;
      busy = 3;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) ready_mdl = 1'b1;
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       go;
    logic [7:0] td;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    model_en  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clr       = 1'b0;
    ready_man = 1'b0;
    rst       = 1'b0;
    cyc();
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.go", 32'(go), 0);
    chk("rst.data", 32'(tx_data), 0);
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int err;
    int nw;
    int maxc;
    int pulses;
    int g0;

    // wr, d, rdy, clr | cnt, full, empty, ovf, go, td
    tv[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tv[3]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    tv[9]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      wr_en     = tv[i].wr;
      wr_data   = tv[i].d;
      ready_man = tv[i].rdy;
      clr       = tv[i].clr;
      cyc();
      chk($sformatf("v%0d.count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(tv[i].full));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tv[i].empty));
      chk($sformatf("v%0d.ovf", i), 32'(ovf), 32'(tv[i].ovf));
      chk($sformatf("v%0d.go", i), 32'(go), 32'(tv[i].go));
      chk($sformatf("v%0d.data", i), 32'(tx_data), 32'(tv[i].td));
    end
    wr_en = 1'b0;
    clr   = 1'b0;

    // burst fill, overflow behaviour, then drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      cyc();
    end
    wr_en = 1'b0;
    chk("burst.full", 32'(full), 1);
    chk("burst.count", 32'(count), 16);
    chk("burst.empty", 32'(empty), 0);
    chk("burst.ovf0", 32'(ovf), 0);
    wr_en = 1'b1; wr_data = 8'hFF;
    cyc();
    wr_en = 1'b0;
    chk("ovf.set", 32'(ovf), 1);
    chk("ovf.count", 32'(count), 16);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf.clr", 32'(ovf), 0);
    wr_en = 1'b1; wr_data = 8'hFF; clr = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("ovf.clr_vs_set", 32'(ovf), 1);
    cyc();
    clr = 1'b0;
    chk("ovf.clr2", 32'(ovf), 0);
    base = tx_log.size();
    model_en = 1'b1;
    wr_en = 1'b1; wr_data = 8'hFE;
    cyc();
    wr_en = 1'b0;
    chk("ovf_pop.count", 32'(count), 15);
    chk("ovf_pop.ovf", 32'(ovf), 1);
    chk("ovf_pop.go", 32'(go), 1);
    chk("ovf_pop.data", 32'(tx_data), 8'h01);
    for (int c = 0; c < 500 && (tx_log.size() - base) < 16; c++) cyc();
    repeat (10) cyc();
    chk("drain.n", 32'(tx_log.size() - base), 16);
    err = 0;
    for (int i = 0; i < 16 && (base + i) < tx_log.size(); i++)
      if (tx_log[base + i] !== 8'(i + 1)) err++;
    chk("drain.order_errs", 32'(err), 0);
    chk("drain.empty", 32'(empty), 1);

    // stream 40 bytes with concurrent writes and pops across wrap
    do_reset();
    model_en = 1'b1;
    base = tx_log.size();
    nw = 0;
    maxc = 0;
    for (int c = 0; c < 3000 && (tx_log.size() - base) < 40; c++) begin
      wr_en   = (nw < 40) && !full;
      wr_data = 8'(nw * 7 + 3);
      cyc();
      if (wr_en) nw++;
      if (int'(count) > maxc) maxc = int'(count);
    end
    wr_en = 1'b0;
    repeat (10) cyc();
    chk("wrap.n", 32'(tx_log.size() - base), 40);
    err = 0;
    for (int i = 0; i < 40 && (base + i) < tx_log.size(); i++)
      if (tx_log[base + i] !== 8'(i * 7 + 3)) err++;
    chk("wrap.order_errs", 32'(err), 0);
    chk("wrap.max_le16", 32'(maxc > 16), 0);
    chk("wrap.reached_full", 32'(maxc), 16);

    // ready held high after a pulse must not retrigger
    do_reset();
    ready_man = 1'b1;
    wr_en = 1'b1; wr_data = 8'h11;
    cyc();
    wr_data = 8'h22;
    cyc();
    wr_en = 1'b0;
    chk("hs.go1", 32'(go), 1);
    chk("hs.data1", 32'(tx_data), 8'h11);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (go) pulses++;
    end
    chk("hs.no_repulse", 32'(pulses), 0);
    chk("hs.count", 32'(count), 1);
    ready_man = 1'b0;
    cyc();
    ready_man = 1'b1;
    cyc();
    chk("hs.go_wait", 32'(go), 0);
    cyc();
    chk("hs.go2", 32'(go), 1);
    chk("hs.data2", 32'(tx_data), 8'h22);

    // asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      cyc();
    end
    wr_en = 1'b0;
    chk("mid.count5", 32'(count), 5);
    ready_man = 1'b1;
    cyc();
    chk("mid.go", 32'(go), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.async_go", 32'(go), 0);
    chk("mid.async_count", 32'(count), 0);
    chk("mid.async_empty", 32'(empty), 1);
    cyc();
    rst = 1'b1;
    g0 = go_seen;
    repeat (20) cyc();
    chk("mid.no_pulse", 32'(go_seen - g0), 0);
    chk("mid.empty_after", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
